// File: rtl/seq_gen_10110.sv
// Serial 10110 pattern transmitter: emits PAT MSB-first once per bit-enable for a
// programmable number of repetitions, concatenated or overlapped, from a registered Moore FSM.
module seq_gen_10110 #(
   parameter logic [4:0] PAT     = 5'b10110,
   parameter int         PAT_LEN = 5,
   parameter int         OVL     = 2,
   parameter int         REP_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             en,
   input  logic             overlap,
   input  logic [REP_W-1:0] rep_cnt,
   output logic             seq_out,
   output logic             seq_valid,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SEND = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam logic [2:0]       LAST_IDX = 3'(PAT_LEN - 1);
   localparam logic [2:0]       OVL_IDX  = 3'(OVL);
   localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

   state_t           state_r;
   logic [2:0]       bit_idx_r;
   logic [REP_W-1:0] reps_left_r;
   logic             ovl_q_r;
   logic             seq_out_r;
   logic             seq_valid_r;
   logic             busy_r;
   logic             done_r;

   // Pattern bit presented at a given index, MSB first.
   function automatic logic pat_bit(input logic [2:0] idx);
      logic [2:0] pos;
      pos = LAST_IDX - idx;
      return PAT[pos];
   endfunction

   // Index at which the next repetition resumes; overlapped reps skip the shared prefix.
   function automatic logic [2:0] rep_start_idx(input logic ovl);
      return ovl ? OVL_IDX : 3'd0;
   endfunction

   // Frame sequencing; outputs are registered alongside the state they decode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         bit_idx_r   <= 3'd0;
         reps_left_r <= {REP_W{1'b0}};
         ovl_q_r     <= 1'b0;
         seq_out_r   <= 1'b0;
         seq_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  state_r     <= SEND;
                  ovl_q_r     <= overlap;
                  reps_left_r <= (rep_cnt == {REP_W{1'b0}}) ? REP_ONE : rep_cnt;
                  bit_idx_r   <= 3'd0;
                  seq_out_r   <= pat_bit(3'd0);
                  seq_valid_r <= 1'b1;
                  busy_r      <= 1'b1;
               end else begin
                  seq_out_r   <= 1'b0;
                  seq_valid_r <= 1'b0;
                  busy_r      <= 1'b0;
               end
            end
            SEND: begin
               if (en) begin
                  if (bit_idx_r < LAST_IDX) begin
                     bit_idx_r <= bit_idx_r + 3'd1;
                     seq_out_r <= pat_bit(bit_idx_r + 3'd1);
                  end else if (reps_left_r > REP_ONE) begin
                     reps_left_r <= reps_left_r - REP_ONE;
                     bit_idx_r   <= rep_start_idx(ovl_q_r);
                     seq_out_r   <= pat_bit(rep_start_idx(ovl_q_r));
                  end else begin
                     state_r     <= DONE;
                     seq_out_r   <= 1'b0;
                     seq_valid_r <= 1'b0;
                     busy_r      <= 1'b0;
                     done_r      <= 1'b1;
                  end
               end else begin
                  state_r <= SEND;
               end
            end
            DONE: begin
               state_r     <= IDLE;
               seq_out_r   <= 1'b0;
               seq_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               done_r      <= 1'b0;
            end
            default: begin
               state_r     <= IDLE;
               bit_idx_r   <= 3'd0;
               seq_out_r   <= 1'b0;
               seq_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               done_r      <= 1'b0;
            end
         endcase
      end
   end

   assign seq_out   = seq_out_r;
   assign seq_valid = seq_valid_r;
   assign busy      = busy_r;
   assign done      = done_r;

endmodule

// File: doc/seq_gen_10110.md
# seq_gen_10110

Serial pattern transmitter that drives the stimulus side of the 10110 sequence-detection path. On a start request it emits the pattern MSB-first, one bit per bit-enable, for a programmable number of repetitions. Repetitions are either back-to-back or overlapped, so a downstream overlapping 10110 detector sees exactly N detections. Output bits come from a registered Moore state machine.

## Interface
- PAT, 5'b10110, pattern sent MSB-first (bit 4 first)
- PAT_LEN, 5, pattern length in bits
- OVL, 2, overlap length: PAT suffix of OVL bits equals PAT prefix ("10")
- REP_W, 4, width of repetition count
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  transmit request; sampled only in IDLE
- en  in  1  bit-advance strobe; the current bit is consumed on an edge with en=1
- overlap  in  1  1 = overlapped repetitions, 0 = concatenated; latched at start
- rep_cnt  in  REP_W  repetitions; 0 treated as 1; latched at start
- seq_out  out  1  serial pattern bit; 0 when not valid
- seq_valid  out  1  seq_out carries a pattern bit
- busy  out  1  transmission in progress (equals seq_valid)
- done  out  1  single-cycle completion pulse

## Operation
- States:
  - IDLE: outputs 0.
  - SEND: emits PAT[4-bit_idx].
  - DONE: done=1 for one cycle, then IDLE.
- Internal registers:
  - bit_idx 0..4
  - reps_left, REP_W bits
  - ovl_q, latched copy of overlap
- IDLE with start=1 at an edge:
  - latch ovl_q=overlap and reps_left=max(rep_cnt,1).
  - set bit_idx=0 and go to SEND.
  - en is ignored on this edge.
- SEND with en=1 at an edge:
  - bit_idx<4: bit_idx+1.
  - bit_idx=4 and reps_left>1: reps_left-1; bit_idx=OVL if ovl_q else 0.
  - bit_idx=4 and reps_left=1: go to DONE.
- SEND with en=0: hold every register; seq_out is stable.
- Total bits: 5·N with overlap=0; 5+3·(N−1) with overlap=1 (N = effective rep count).
- start while in SEND or DONE is ignored and not queued.
- rep_cnt and overlap changes after the start edge have no effect on the current frame.
- All outputs are decoded from state registers only (Moore); no combinational path from inputs to outputs.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, seq_out=0, seq_valid=0, busy=0, done=0, bit_idx=0, reps_left=0, ovl_q=0.
- Start accepted at edge k:
  - seq_valid=busy=1 and seq_out=PAT[4]=1 from cycle k+1.
- A bit is presented for at least one cycle; its duration is set by en.
  - With en held at 1, a new bit is presented every cycle.
- The last bit is consumed at edge m:
  - cycle m+1 has done=1 with seq_valid=busy=0.
  - cycle m+2 is IDLE, and a start sampled at edge m+2 is accepted.
- Minimum frame, N=1 with en=1: 5 valid cycles, then 1 done cycle.
- rst asserted mid-frame: outputs go to 0 asynchronously and no done pulse is emitted.
  - After rst deasserts, the block waits in IDLE for a new start.
- start and rst asserted together: rst wins.

## Test plan
- Reset check: rst=1 with random inputs -> all outputs 0.
  - After release with start=0 for 10 cycles, outputs stay 0.
- Basic frame: rep_cnt=1, overlap=0, en=1, start pulse -> seq_out 1,0,1,1,0 on 5 valid cycles.
  - done on the 6th cycle; busy low after.
- Concatenated frame: rep_cnt=3, overlap=0, en=1 -> 15 bits 101101011010110, done once.
  - An overlapping 10110 detector fed the stream counts 3.
- Overlapped frame: rep_cnt=3, overlap=1, en=1 -> 11 bits 10110110110, done once.
  - The detector counts 3.
  - rep_cnt=0 gives the same result as rep_cnt=1.
- Gapped enable: en asserted every 3rd cycle, rep_cnt=2, overlap=1 -> bits 10110110.
  - Each bit held exactly 3 cycles.
  - start pulses mid-frame are ignored.
  - Changing rep_cnt/overlap mid-frame has no effect.
- Reset mid-frame: rst pulsed during the 3rd bit of a rep_cnt=4 frame.
  - Outputs go to 0 immediately, with no done pulse.
  - A new start then yields a clean frame beginning with 1.
